// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - asynchronous serial frame receiver: start, DATA_W LSB-first bits, stop
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sin,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);
    localparam int H  = BIT_CYCLES / 2;
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              s1, sin_s;
    logic              load, ferr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1    <= 1'b1;
            sin_s <= 1'b1;
        end else begin
            s1    <= sin;
            sin_s <= s1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            valid     <= load;
            frame_err <= ferr;
            if (load) begin
                dout <= shreg;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        shreg_nxt = shreg;
        load      = 1'b0;
        ferr      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!sin_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = sin_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt        = '0;
                    shreg_nxt[idx] = sin_s;
                    idx_nxt        = idx + IW'(1);
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (sin_s) begin
                        load      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr      = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_nxt = '0;
                // a stuck-low line must return high before another start can be seen
                if (sin_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed self-checking bench for serial_frame_rx
module tb_serial_frame_rx;
    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sin = 1'b1;
    logic [7:0] dout;
    logic       valid, frame_err, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int both_cnt = 0;
    int v_cyc[$];
    int f_cyc[$];
    logic [7:0] v_dat[$];

    serial_frame_rx #(.DATA_W(8), .BIT_CYCLES(BC)) dut (
        .clk(clk), .rstn(rstn), .sin(sin), .dout(dout),
        .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(dout);
        end
        if (frame_err) f_cyc.push_back(cyc);
        if (busy) busy_cnt++;
        if (valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_events();
        v_cyc.delete();
        v_dat.delete();
        f_cyc.delete();
        busy_cnt = 0;
    endtask

    // Called right after a negedge; leaves sin at the stop value after the stop bit's last cycle.
    task automatic send_frame(input logic [7:0] data, input logic stop, output int e);
        sin = 1'b0;
        e = cyc + 1;
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sin = data[i];
            repeat (BC) @(negedge clk);
        end
        sin = stop;
        repeat (BC) @(negedge clk);
    endtask

    function automatic int q_int(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    function automatic logic [7:0] q_dat(input logic [7:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 8'hxx;
    endfunction

    initial begin
        int e, e2;
        logic [9:0] fb;

        // 1: reset
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {dout, valid, frame_err, busy}, 32'h0);
        end
        rstn = 1'b1;
        clear_events();
        repeat (50) @(negedge clk);
        check("idle_valid_events", v_cyc.size(), 0);
        check("idle_ferr_events", f_cyc.size(), 0);
        check("idle_busy_cycles", busy_cnt, 0);
        check("idle_dout", dout, 8'h00);

        // 2: good frame 0xA5
        clear_events();
        send_frame(8'hA5, 1'b1, e);
        sin = 1'b1;
        repeat (2) @(negedge clk);
        check("good_valid_count", v_cyc.size(), 1);
        check("good_valid_cycle", q_int(v_cyc, 0), e + 40);
        check("good_dout", q_dat(v_dat, 0), 8'hA5);
        check("good_ferr_count", f_cyc.size(), 0);
        check("good_busy_low", busy, 1'b0);

        // 3: one-cycle glitch
        repeat (5) @(negedge clk);
        clear_events();
        sin = 1'b0;
        @(negedge clk);
        sin = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_busy_cycles", busy_cnt, 2);
        check("glitch_valid_count", v_cyc.size(), 0);
        check("glitch_ferr_count", f_cyc.size(), 0);
        check("glitch_dout", dout, 8'hA5);

        // 4: framing error 0x3C with stop=0, line stuck low
        clear_events();
        send_frame(8'h3C, 1'b0, e);
        repeat (20) @(negedge clk);
        check("ferr_count", f_cyc.size(), 1);
        check("ferr_cycle", q_int(f_cyc, 0), e + 40);
        check("ferr_valid_count", v_cyc.size(), 0);
        check("ferr_dout_held", dout, 8'hA5);
        check("ferr_busy_stuck", busy, 1'b1);
        sin = 1'b1;
        @(negedge clk);
        check("ferr_busy_x1", busy, 1'b1);
        @(negedge clk);
        check("ferr_busy_x2", busy, 1'b1);
        @(negedge clk);
        check("ferr_busy_released", busy, 1'b0);

        // 5: back-to-back 0x00 then 0xFF
        repeat (5) @(negedge clk);
        clear_events();
        send_frame(8'h00, 1'b1, e);
        send_frame(8'hFF, 1'b1, e2);
        sin = 1'b1;
        repeat (2) @(negedge clk);
        check("b2b_valid_count", v_cyc.size(), 2);
        check("b2b_first_cycle", q_int(v_cyc, 0), e + 40);
        check("b2b_second_cycle", q_int(v_cyc, 1), e + 80);
        check("b2b_first_dout", q_dat(v_dat, 0), 8'h00);
        check("b2b_second_dout", q_dat(v_dat, 1), 8'hFF);
        check("b2b_ferr_count", f_cyc.size(), 0);

        // 6: reset mid-frame, then 0x81
        repeat (5) @(negedge clk);
        clear_events();
        fb = {1'b1, 8'h5A, 1'b0};
        for (int j = 0; j < 20; j++) begin
            sin = fb[j / BC];
            @(negedge clk);
        end
        rstn = 1'b0;
        sin = 1'b1;
        #1;
        check("midrst_immediate", {dout, busy}, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_hold", {dout, valid, frame_err, busy}, 32'h0);
        end
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_no_valid", v_cyc.size(), 0);
        check("midrst_no_ferr", f_cyc.size(), 0);
        send_frame(8'h81, 1'b1, e);
        sin = 1'b1;
        repeat (2) @(negedge clk);
        check("after_rst_valid_count", v_cyc.size(), 1);
        check("after_rst_cycle", q_int(v_cyc, 0), e + 40);
        check("after_rst_dout", q_dat(v_dat, 0), 8'h81);

        check("valid_ferr_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receives asynchronous serial frames on a single 1-bit line and reassembles them into parallel words. Frame format: start bit (0), DATA_W data bits sent LSB first, one stop bit (1).
- Each bit lasts BIT_CYCLES clocks, and the line idles high.
- Sits at the receiving end of the lab serial link. Delivers each word with a one-cycle valid pulse and flags framing errors.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16)
- BIT_CYCLES, 4, clocks per bit; even, >= 4; H = BIT_CYCLES/2

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- sin  input  1  serial line; asynchronous to clk; idle = 1
- dout  output  DATA_W  last correctly framed word; holds until the next good frame
- valid  output  1  one-cycle pulse; dout is updated in the same cycle
- frame_err  output  1  one-cycle pulse when the stop bit samples 0
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rstn=0):
  - Both synchronizer flops are set to 1.
  - FSM goes to IDLE; bit counter and bit index go to 0.
  - dout=0, valid=0, frame_err=0, busy=0.
  - Reset takes effect immediately, including mid-frame. Any partially assembled shift data is discarded.
- Synchronizer:
  - sin passes through two flops to produce sin_s.
  - The FSM uses only sin_s, so it lags sin by 2 edges.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - On an edge where sin_s==0, go to START and clear the counter.
- START:
  - On the H-th edge after entry, sample sin_s.
  - If the sample is 1: false start, return to IDLE with no outputs.
  - If the sample is 0: go to DATA with bit index 0.
- DATA:
  - On every BIT_CYCLES-th edge, sample sin_s into bit[index], filling LSB first.
  - After sampling bit DATA_W-1, go to STOP.
- STOP:
  - Sample sin_s BIT_CYCLES edges after the last data sample.
  - If the sample is 1:
    - Load dout from the shift register and assert valid for exactly one cycle.
    - Go to IDLE. A start bit that follows immediately is detected on the next edge.
  - If the sample is 0:
    - Assert frame_err for exactly one cycle; dout is unchanged and valid stays 0.
    - Go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until sin_s==1, then go to IDLE. This prevents a stuck-low line from being read as repeated frames.
- Timing: let E be the edge at which sin is first sampled low.
  - valid or frame_err is asserted on edge E + 2 + H + (DATA_W+1)*BIT_CYCLES.
  - With the defaults this is E+40.
  - All sample points fall at mid-bit.
- valid and frame_err are never high in the same cycle.
- busy:
  - Rises on the edge after IDLE detects the start bit.
  - Falls on the edge that enters IDLE.
- sin is not checked while in DATA.

Test Plan:
1. Reset:
   - Stimulus: rstn=0 for 3 cycles with sin=1, then rstn=1.
   - Required: dout=0, valid=0, frame_err=0, busy=0 throughout; no output events for 50 idle cycles.
2. Good frame:
   - Stimulus: send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1, each bit 4 cycles starting at edge E.
   - Required: valid=1 for exactly one cycle at E+40, dout=8'hA5, frame_err stays 0, busy=0 by E+41.
3. Glitch rejection:
   - Stimulus: sin low for 1 cycle only.
   - Required: busy pulses for about 2 cycles then returns to 0; no valid, no frame_err; dout is unchanged.
4. Framing error:
   - Stimulus: after test 2, send 0x3C with stop=0, then hold sin=0 for 20 more cycles, then set sin=1.
   - Required: frame_err one-cycle pulse at E+40, dout stays 8'hA5, no valid, busy stays 1 until 2 edges after sin returns high.
5. Back-to-back frames:
   - Stimulus: send 0x00 then 0xFF with no idle gap between the stop bit and the next start bit.
   - Required: two valid pulses 40 cycles apart, showing dout=8'h00 then dout=8'hFF.
6. Reset mid-frame:
   - Stimulus: start frame 0x5A, then drive rstn=0 at E+20 for 3 cycles; after the line has been idle, send 0x81.
   - Required: dout=0 and busy=0 during reset; no event from the aborted frame; the next frame gives valid with dout=8'h81.
